// File: rtl/lsq_id_returner.sv
// Return-side companion of the LSQ free-ID queue: buffers up to two freed IDs per
// cycle and writes them back one per cycle. Optional same-cycle bypass: LSQ_RET_BYPASS_EN.
module lsq_id_returner #(
  parameter int IDWIDE   = 4,
  parameter int PENDDEEP = 4
) (
  input  logic                          Clk,
  input  logic                          Rest,
  input  logic [1:0]                    RetireValid,
  input  logic [IDWIDE-1:0]             RetireId0,
  input  logic [IDWIDE-1:0]             RetireId1,
  output logic                          RetireReady,
  input  logic                          FlushReq,
  input  logic                          CriqFull,
  output logic                          Wable,
  output logic [IDWIDE-1:0]             Din,
  output logic                          CriqClean,
  output logic [$clog2(PENDDEEP+1)-1:0] PendCnt
);

  localparam int PW = $clog2(PENDDEEP);
  localparam int CW = $clog2(PENDDEEP+1);
  localparam logic [CW-1:0] READY_MAX = CW'(PENDDEEP - 2);

  // state    | meaning
  // ST_IDLE  | nothing buffered
  // ST_DRAIN | IDs pending, writing back one per cycle
  // ST_FLUSH | clean pulse to free-ID queue, buffer cleared at end of cycle
  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_FLUSH} state_e;

  state_e            state_q, state_d;
  logic [IDWIDE-1:0] buf_q [PENDDEEP];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic          bypass;
  logic          accept;
  logic          push0;
  logic          push1;
  logic          pop;
  logic [PW-1:0] wr_ptr0;
  logic [PW-1:0] wr_ptr1;

  always_comb begin
    bypass = 1'b0;
`ifdef LSQ_RET_BYPASS_EN
    bypass = (state_q == ST_IDLE) && (count_q == '0) && !CriqFull &&
             RetireValid[0] && !FlushReq;
`endif
    RetireReady = (count_q <= READY_MAX) && (state_q != ST_FLUSH);
    accept      = RetireReady && !FlushReq;
    push0       = accept && RetireValid[0] && !bypass;
    push1       = accept && RetireValid[1];
    // A flush request suppresses the write-back so nothing leaves mid-flush
    pop         = (count_q != '0) && !CriqFull && (state_q != ST_FLUSH) && !FlushReq;
    Wable       = pop || bypass;
    Din         = bypass ? RetireId0 : buf_q[head_q];
    CriqClean   = (state_q == ST_FLUSH);
    PendCnt     = count_q;

    wr_ptr0 = tail_q;
    wr_ptr1 = tail_q + PW'(push0);
    tail_d  = tail_q + PW'(push0) + PW'(push1);
    head_d  = head_q + PW'(pop);
    count_d = count_q + CW'(push0) + CW'(push1) - CW'(pop);

    if (state_q == ST_FLUSH) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end

    state_d = state_q;
    if (FlushReq) begin
      state_d = ST_FLUSH;
    end else if (state_q == ST_FLUSH) begin
      state_d = ST_IDLE;
    end else if (count_d == '0) begin
      state_d = ST_IDLE;
    end else begin
      state_d = ST_DRAIN;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q <= ST_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < PENDDEEP; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push0) begin
        buf_q[wr_ptr0] <= RetireId0;
      end
      if (push1) begin
        buf_q[wr_ptr1] <= RetireId1;
      end
    end
  end

endmodule

// File: tb/tb_lsq_id_returner.sv
// Self-checking bench for lsq_id_returner against a queue-based reference model.
module tb_lsq_id_returner;
  localparam int IDWIDE   = 4;
  localparam int PENDDEEP = 4;
  localparam int CW       = $clog2(PENDDEEP+1);
  localparam int TW       = 3 + CW + IDWIDE;
  typedef logic [TW-1:0] tr_t;

  logic              Clk = 1'b0;
  logic              Rest;
  logic [1:0]        RetireValid;
  logic [IDWIDE-1:0] RetireId0, RetireId1;
  logic              RetireReady;
  logic              FlushReq, CriqFull;
  logic              Wable;
  logic [IDWIDE-1:0] Din;
  logic              CriqClean;
  logic [CW-1:0]     PendCnt;

  lsq_id_returner #(.IDWIDE(IDWIDE), .PENDDEEP(PENDDEEP)) dut (
    .Clk(Clk), .Rest(Rest), .RetireValid(RetireValid), .RetireId0(RetireId0),
    .RetireId1(RetireId1), .RetireReady(RetireReady), .FlushReq(FlushReq),
    .CriqFull(CriqFull), .Wable(Wable), .Din(Din), .CriqClean(CriqClean),
    .PendCnt(PendCnt)
  );

  always #5 Clk = ~Clk;

  int  mq[$];
  bit  m_flush;
  tr_t exp_tr[$], obs_tr[$];
  int  obs_ids[$];
  int  n_checks, n_errors;
  logic obs_wable, obs_ready, obs_clean;
  logic [IDWIDE-1:0] obs_din;
  logic [CW-1:0] obs_cnt;

  task automatic clear_traces();
    exp_tr.delete(); obs_tr.delete(); obs_ids.delete();
  endtask

  task automatic do_reset();
    Rest = 1'b1; RetireValid = 2'b00; RetireId0 = '0; RetireId1 = '0;
    FlushReq = 1'b0; CriqFull = 1'b0;
    repeat (2) begin @(posedge Clk); #1; end
    Rest = 1'b0;
    mq.delete(); m_flush = 1'b0;
  endtask

  // Applies one cycle of inputs, records expected and observed outputs, advances the model.
  task automatic drive_cycle(input logic [1:0] rv, input logic [IDWIDE-1:0] i0,
                             input logic [IDWIDE-1:0] i1, input logic fl, input logic full);
    bit byp;
    logic e_ready, e_wable, e_clean;
    logic [IDWIDE-1:0] e_din;
    RetireValid = rv; RetireId0 = i0; RetireId1 = i1; FlushReq = fl; CriqFull = full;
    @(negedge Clk);
    byp = 1'b0;
`ifdef LSQ_RET_BYPASS_EN
    byp = !m_flush && (mq.size() == 0) && !full && rv[0] && !fl;
`endif
    e_ready = !m_flush && ((PENDDEEP - mq.size()) >= 2);
    e_wable = byp || (!m_flush && !fl && !full && (mq.size() > 0));
    e_clean = m_flush;
    e_din   = byp ? i0 : ((e_wable && mq.size() > 0) ? IDWIDE'(mq[0]) : '0);
    exp_tr.push_back({e_ready, e_wable, e_clean, CW'(mq.size()), e_wable ? e_din : '0});
    obs_ready = RetireReady; obs_wable = Wable; obs_clean = CriqClean;
    obs_din = Din; obs_cnt = PendCnt;
    obs_tr.push_back({obs_ready, obs_wable, obs_clean, obs_cnt, obs_wable ? obs_din : '0});
    if (obs_wable === 1'b1) obs_ids.push_back(int'(obs_din));
    if (m_flush) mq.delete();
    if (fl) m_flush = 1'b1;
    else if (m_flush) m_flush = 1'b0;
    else begin
      if (e_wable && !byp) void'(mq.pop_front());
      if (e_ready) begin
        if (rv[0] && !byp) mq.push_back(int'(i0));
        if (rv[1]) mq.push_back(int'(i1));
      end
    end
    @(posedge Clk); #1;
  endtask

  task automatic idle(input int n, input logic full);
    for (int k = 0; k < n; k++) drive_cycle(2'b00, '0, '0, 1'b0, full);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge Clk);
    n_checks += 5;
    if (Wable !== 1'b0)       begin n_errors++; $display("FAIL reset_wable got %b want 0", Wable); end
    if (Din !== '0)           begin n_errors++; $display("FAIL reset_din got %h want 0", Din); end
    if (CriqClean !== 1'b0)   begin n_errors++; $display("FAIL reset_clean got %b want 0", CriqClean); end
    if (RetireReady !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b want 1", RetireReady); end
    if (PendCnt !== '0)       begin n_errors++; $display("FAIL reset_cnt got %0d want 0", PendCnt); end
    @(posedge Clk); #1;
    clear_traces();
    drive_cycle(2'b11, 4'd1, 4'd2, 1'b0, 1'b1);
    drive_cycle(2'b01, 4'd3, 4'd0, 1'b0, 1'b1);
    Rest = 1'b1; @(posedge Clk); #1; Rest = 1'b0;
    mq.delete(); m_flush = 1'b0;
    @(negedge Clk);
    n_checks += 3;
    if (PendCnt !== '0)       begin n_errors++; $display("FAIL midreset_cnt got %0d want 0", PendCnt); end
    if (CriqClean !== 1'b0)   begin n_errors++; $display("FAIL midreset_clean got %b want 0", CriqClean); end
    if (Wable !== 1'b0)       begin n_errors++; $display("FAIL midreset_wable got %b want 0", Wable); end
    @(posedge Clk); #1;
  endtask

  task automatic test_single();
    int want[$];
    do_reset(); clear_traces();
    idle(2, 1'b0);
    drive_cycle(2'b01, 4'd5, 4'd0, 1'b0, 1'b0);
    idle(3, 1'b0);
    want = '{5};
    for (int i = 0; i < exp_tr.size(); i++) begin
      n_checks++;
      if (obs_tr[i] !== exp_tr[i]) begin n_errors++; $display("FAIL single cycle %0d got %h want %h", i, obs_tr[i], exp_tr[i]); end
    end
    n_checks++;
    if (obs_ids.size() != want.size() || (obs_ids.size() > 0 && obs_ids[0] != want[0])) begin
      n_errors++; $display("FAIL single_stream got %p want %p", obs_ids, want);
    end
  endtask

  task automatic test_dual_full();
    int want[$];
    do_reset(); clear_traces();
    drive_cycle(2'b11, 4'd3, 4'd7, 1'b0, 1'b1);
    drive_cycle(2'b11, 4'd3, 4'd7, 1'b0, 1'b1);
    drive_cycle(2'b00, 4'd0, 4'd0, 1'b0, 1'b1);
    n_checks += 2;
    if (obs_cnt !== CW'(4))  begin n_errors++; $display("FAIL dual_cnt got %0d want 4", obs_cnt); end
    if (obs_ready !== 1'b0)  begin n_errors++; $display("FAIL dual_ready got %b want 0", obs_ready); end
    idle(6, 1'b0);
    want = '{3, 7, 3, 7};
    for (int i = 0; i < exp_tr.size(); i++) begin
      n_checks++;
      if (obs_tr[i] !== exp_tr[i]) begin n_errors++; $display("FAIL dual cycle %0d got %h want %h", i, obs_tr[i], exp_tr[i]); end
    end
    n_checks++;
    if (obs_ids.size() != want.size()) begin n_errors++; $display("FAIL dual_stream_len got %0d want %0d", obs_ids.size(), want.size()); end
    else for (int i = 0; i < want.size(); i++)
      if (obs_ids[i] != want[i]) begin n_errors++; $display("FAIL dual_stream[%0d] got %0d want %0d", i, obs_ids[i], want[i]); end
  endtask

  task automatic test_push_pop();
    int want[$];
    do_reset(); clear_traces();
    drive_cycle(2'b11, 4'd1, 4'd2, 1'b0, 1'b1);
    drive_cycle(2'b01, 4'd9, 4'd0, 1'b0, 1'b0);
    drive_cycle(2'b00, 4'd0, 4'd0, 1'b0, 1'b1);
    n_checks++;
    if (obs_cnt !== CW'(2)) begin n_errors++; $display("FAIL pushpop_cnt got %0d want 2", obs_cnt); end
    idle(4, 1'b0);
    want = '{1, 2, 9};
    for (int i = 0; i < exp_tr.size(); i++) begin
      n_checks++;
      if (obs_tr[i] !== exp_tr[i]) begin n_errors++; $display("FAIL pushpop cycle %0d got %h want %h", i, obs_tr[i], exp_tr[i]); end
    end
    n_checks++;
    if (obs_ids.size() != want.size()) begin n_errors++; $display("FAIL pushpop_stream_len got %0d want %0d", obs_ids.size(), want.size()); end
    else for (int i = 0; i < want.size(); i++)
      if (obs_ids[i] != want[i]) begin n_errors++; $display("FAIL pushpop_stream[%0d] got %0d want %0d", i, obs_ids[i], want[i]); end
  endtask

  task automatic test_flush();
    int want[$];
    do_reset(); clear_traces();
    drive_cycle(2'b11, 4'd1, 4'd2, 1'b0, 1'b1);
    drive_cycle(2'b01, 4'd4, 4'd0, 1'b0, 1'b1);
    drive_cycle(2'b11, 4'd10, 4'd11, 1'b1, 1'b0);
    drive_cycle(2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
    n_checks += 2;
    if (obs_clean !== 1'b1) begin n_errors++; $display("FAIL flush_clean got %b want 1", obs_clean); end
    if (obs_wable !== 1'b0) begin n_errors++; $display("FAIL flush_wable got %b want 0", obs_wable); end
    drive_cycle(2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
    n_checks += 2;
    if (obs_cnt !== '0)     begin n_errors++; $display("FAIL flush_cnt got %0d want 0", obs_cnt); end
    if (obs_ready !== 1'b1) begin n_errors++; $display("FAIL flush_ready got %b want 1", obs_ready); end
    drive_cycle(2'b01, 4'd13, 4'd0, 1'b0, 1'b1);
    drive_cycle(2'b00, 4'd0, 4'd0, 1'b1, 1'b0);
    drive_cycle(2'b01, 4'd14, 4'd0, 1'b1, 1'b0);
    idle(2, 1'b0);
    drive_cycle(2'b01, 4'd12, 4'd0, 1'b0, 1'b0);
    idle(3, 1'b0);
    want = '{12};
    for (int i = 0; i < exp_tr.size(); i++) begin
      n_checks++;
      if (obs_tr[i] !== exp_tr[i]) begin n_errors++; $display("FAIL flush cycle %0d got %h want %h", i, obs_tr[i], exp_tr[i]); end
    end
    n_checks++;
    if (obs_ids.size() != want.size() || (obs_ids.size() > 0 && obs_ids[0] != want[0])) begin
      n_errors++; $display("FAIL flush_stream got %p want %p", obs_ids, want);
    end
  endtask

  task automatic test_wrap();
    do_reset(); clear_traces();
    for (int k = 0; k < 10; k++) drive_cycle(2'b01, IDWIDE'(k), '0, 1'b0, 1'b0);
    idle(3, 1'b0);
    for (int i = 0; i < exp_tr.size(); i++) begin
      n_checks++;
      if (obs_tr[i] !== exp_tr[i]) begin n_errors++; $display("FAIL wrap cycle %0d got %h want %h", i, obs_tr[i], exp_tr[i]); end
    end
    n_checks++;
    if (obs_ids.size() != 10) begin n_errors++; $display("FAIL wrap_stream_len got %0d want 10", obs_ids.size()); end
    else for (int i = 0; i < 10; i++)
      if (obs_ids[i] != i) begin n_errors++; $display("FAIL wrap_stream[%0d] got %0d want %0d", i, obs_ids[i], i); end
  endtask

  task automatic test_random();
    do_reset(); clear_traces();
    for (int k = 0; k < 400; k++) begin
      drive_cycle(2'($urandom_range(0, 3)), IDWIDE'($urandom_range(0, 15)),
                  IDWIDE'($urandom_range(0, 15)), ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 9) < 3));
    end
    idle(6, 1'b0);
    for (int i = 0; i < exp_tr.size(); i++) begin
      n_checks++;
      if (obs_tr[i] !== exp_tr[i]) begin n_errors++; $display("FAIL random cycle %0d got %h want %h", i, obs_tr[i], exp_tr[i]); end
    end
  endtask

`ifdef LSQ_RET_BYPASS_EN
  task automatic test_bypass();
    do_reset(); clear_traces();
    idle(1, 1'b0);
    drive_cycle(2'b01, 4'd6, 4'd0, 1'b0, 1'b0);
    n_checks += 2;
    if (obs_wable !== 1'b1) begin n_errors++; $display("FAIL bypass_wable got %b want 1", obs_wable); end
    if (obs_din !== 4'd6)   begin n_errors++; $display("FAIL bypass_din got %0d want 6", obs_din); end
    drive_cycle(2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
    n_checks++;
    if (obs_cnt !== '0) begin n_errors++; $display("FAIL bypass_cnt got %0d want 0", obs_cnt); end
    for (int i = 0; i < exp_tr.size(); i++) begin
      n_checks++;
      if (obs_tr[i] !== exp_tr[i]) begin n_errors++; $display("FAIL bypass cycle %0d got %h want %h", i, obs_tr[i], exp_tr[i]); end
    end
  endtask
`endif

  initial begin
    n_checks = 0; n_errors = 0;
    test_reset();
    test_single();
    test_dual_full();
    test_push_pop();
    test_flush();
    test_wrap();
`ifdef LSQ_RET_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsq_id_returner.md
# lsq_id_returner

Return-side companion of the LSQ free-ID circular queue. Collects LSQ entry IDs freed at commit (up to two per cycle), buffers them in a small in-order pending FIFO, and writes them back into the free-ID queue one per cycle through its `Wable`/`Din` write port, honouring `CriqFull`. On pipeline flush it discards pending returns and pulses `CriqClean` so the free-ID queue reloads its initial ID set.

## Interface
Parameters:
- `IDWIDE`, 4, width of an LSQ entry ID; matches the free-ID queue data width.
- `PENDDEEP`, 4, pending-buffer depth; power of two, ≥ 2.

Ports:
- `Clk`  in  1  clock; all logic on rising edge.
- `Rest`  in  1  reset, synchronous, active-high.
- `RetireValid`  in  2  per-lane "entry freed this cycle"; lane 0 older than lane 1.
- `RetireId0`  in  IDWIDE  lane 0 freed ID.
- `RetireId1`  in  IDWIDE  lane 1 freed ID.
- `RetireReady`  out  1  buffer can accept two IDs this cycle.
- `FlushReq`  in  1  pipeline flush request.
- `CriqFull`  in  1  free-ID queue full.
- `Wable`  out  1  write strobe to free-ID queue.
- `Din`  out  IDWIDE  ID written when `Wable`=1.
- `CriqClean`  out  1  one-cycle clean pulse to free-ID queue.
- `PendCnt`  out  $clog2(PENDDEEP+1)  IDs currently buffered.

## Operation
- Pending buffer: circular, head/tail pointers of width log2(PENDDEEP), explicit count `PendCnt`; pointers wrap modulo PENDDEEP.
- Push: each cycle, lane 0 (if valid) then lane 1 (if valid) are written at tail, tail+1 in that order; count += number pushed.
- Pushes occur only when `RetireReady`=1. Retire with `RetireReady`=0 is a protocol violation; IDs are dropped, buffer unchanged.
- `RetireReady` = (PENDDEEP − PendCnt ≥ 2) && state≠FLUSH; computed from current count, ignores same-cycle pop.
- Pop: `Wable` = (PendCnt>0) && !`CriqFull` && state≠FLUSH; `Din` = buffer[head]; on `Wable`, head advances, count −1.
- Push and pop in the same cycle: both apply; count += pushes − 1.
- FSM states: IDLE (PendCnt=0), DRAIN (PendCnt>0), FLUSH.
  - IDLE → DRAIN when any lane pushes.
  - DRAIN → IDLE when count becomes 0 after the cycle's push/pop.
  - Any state → FLUSH when `FlushReq`=1 (highest priority; same-cycle retires are dropped, no pop).
  - FLUSH: `CriqClean`=1, `Wable`=0, `RetireReady`=0, head/tail/count cleared at end of cycle → IDLE next cycle.
  - `FlushReq` held high: remains in FLUSH, `CriqClean` held high.
- Order: IDs leave in exact push order (lane 0 before lane 1 within a cycle).

## Timing
- Reset (`Rest`=1 at edge): state IDLE, head=tail=0, `PendCnt`=0, buffer contents 0. After reset: `Wable`=0, `Din`=0, `CriqClean`=0, `RetireReady`=1.
- Reset mid-operation discards pending IDs without a `CriqClean` pulse; the free-ID queue is reset by the same system reset.
- Retire at cycle t → buffered at edge t → earliest `Wable` in cycle t+1 (one-cycle latency).
- `Wable`, `Din`, and `RetireReady` are combinational from registered state plus `CriqFull`; `CriqClean` is decoded from the state register.
- `CriqFull` stalls the drain; contents hold. Drain resumes in the first cycle `CriqFull`=0.
- `FlushReq` at cycle t → `CriqClean`=1 during cycle t+1 → `RetireReady`=1 at t+2.

## Configuration
- `LSQ_RET_BYPASS_EN` defined: when `PendCnt`=0, state IDLE, `CriqFull`=0, and lane 0 is valid, lane 0's ID drives `Wable`/`Din` in the same cycle and is not buffered. Lane 1, if valid, is buffered. `FlushReq` blocks bypass. This gives zero latency.
- Undefined: no bypass; one-cycle latency for all IDs.

## Test plan
- Reset, then single retire ID 5 at cycle 3 → `Wable`=1, `Din`=5 at cycle 4; `PendCnt` goes 1 → 0; state returns to IDLE.
- Dual retire (3, 7) per cycle for 2 cycles with `CriqFull`=1 → `PendCnt`=4, `RetireReady`=0. Release `CriqFull` → `Din` sequence 3, 7, 3, 7 on 4 consecutive cycles.
- Push+pop same cycle with PendCnt=2, lane 0 pushes ID 9 → PendCnt stays 2; ID 9 emerges third.
- `FlushReq` with PendCnt=3 and a simultaneous retire → next cycle `CriqClean`=1, `Wable`=0. Following cycle: PendCnt=0, `RetireReady`=1, no stale IDs are ever emitted.
- Pointer wrap: 10 cycles of single retire IDs 0..9 under continuous drain → output sequence 0..9 in order.
- With `LSQ_RET_BYPASS_EN`: idle, retire ID 6 → `Wable`=1, `Din`=6 in the same cycle, and `PendCnt` stays 0.
